// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register-address width comes from `ASIZE (define.v); a 5-bit fallback keeps the
// slice self-contained when define.v is not on the compile line.
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif

package hazard_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_e;

  // EX operand mux selects.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  // A used, non-zero source matches a stage that writes the same register.
  function automatic logic src_match(input logic              used,
                                     input logic [`ASIZE-1:0] src,
                                     input logic [`ASIZE-1:0] waddr,
                                     input logic              wen);
    return used && wen && (src == waddr) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand match/select logic: reports an ID/EX match and picks the
// forwarding source, EX/MEM taking precedence over DM/WB.
`ifndef ASIZE
`define ASIZE 5
`endif

module fwd_unit (
  input  logic [`ASIZE-1:0] src,
  input  logic              used,
  input  logic [`ASIZE-1:0] ex_waddr,
  input  logic              ex_wen,
  input  logic [`ASIZE-1:0] mem_waddr,
  input  logic              mem_wen,
  input  logic [`ASIZE-1:0] wb_waddr,
  input  logic              wb_wen,
  output logic              ex_hit,
  output logic [1:0]        fwd
);
  import hazard_pkg::*;

  logic mem_hit;
  logic wb_hit;

  // Stage matches and forwarding priority.
  always_comb begin
    ex_hit  = src_match(used, src, ex_waddr, ex_wen);
    mem_hit = src_match(used, src, mem_waddr, mem_wen);
    wb_hit  = src_match(used, src, wb_waddr, wb_wen);
    fwd     = FWD_RF;
    if (mem_hit) begin
      fwd = FWD_EXMEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stage enables, bubble/flush
// controls, operand-forwarding selects, memory-wait freeze and timeout fault.
// Optional feature macro: FORWARD_EN (undefined: no forwarding, any RAW match stalls).
`ifndef ASIZE
`define ASIZE 5
`endif

module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [`ASIZE-1:0] id_rs1,
  input  logic [`ASIZE-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [`ASIZE-1:0] ex_waddr,
  input  logic              ex_wen,
  input  logic              ex_memtoreg,
  input  logic [`ASIZE-1:0] mem_waddr,
  input  logic              mem_wen,
  input  logic              mem_req,
  input  logic              dm_ready,
  input  logic [`ASIZE-1:0] wb_waddr,
  input  logic              wb_wen,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              wb_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  stall_cycles
);
  import hazard_pkg::*;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d, wait_inc;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic       a_ex_hit, b_ex_hit;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       mem_block, load_use, data_stall, count_cycle;

  fwd_unit u_fwd_a (
    .src       (id_rs1),
    .used      (id_rs1_used),
    .ex_waddr  (ex_waddr),
    .ex_wen    (ex_wen),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .wb_waddr  (wb_waddr),
    .wb_wen    (wb_wen),
    .ex_hit    (a_ex_hit),
    .fwd       (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .src       (id_rs2),
    .used      (id_rs2_used),
    .ex_waddr  (ex_waddr),
    .ex_wen    (ex_wen),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .wb_waddr  (wb_waddr),
    .wb_wen    (wb_wen),
    .ex_hit    (b_ex_hit),
    .fwd       (fwd_b_sel)
  );

  assign mem_block = mem_req & ~dm_ready;
  assign load_use  = (a_ex_hit | b_ex_hit) & ex_memtoreg;
  assign wait_inc  = wait_q + 8'd1;

`ifdef FORWARD_EN
  assign data_stall = load_use;
  assign fwd_a      = fwd_a_sel;
  assign fwd_b      = fwd_b_sel;
`else
  // Without forwarding every in-flight producer is a hazard; loads are a subset.
  assign data_stall = load_use | a_ex_hit | b_ex_hit |
                      (fwd_a_sel != FWD_RF) | (fwd_b_sel != FWD_RF);
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
`endif

  // Next-state, wait counter and pipeline controls by priority.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    wb_bubble   = 1'b0;
    unique case (state_q)
      RST_HOLD, FAULT: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        wb_bubble   = 1'b1;
        if (state_q == RST_HOLD) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wait_d = '0;
        if (mem_block) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          wb_bubble = 1'b1;
          state_d   = MEM_WAIT;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (data_stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        wb_bubble = 1'b1;
        if (dm_ready) begin
          state_d = RUN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TimeoutCnt) begin
            state_d = FAULT;
          end
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Stall accounting; the post-reset hold cycle is not a pipeline stall.
  always_comb begin
    count_cycle = (~pc_en | id_ex_flush) & (state_q != RST_HOLD);
    stall_d     = stall_q;
    if (count_cycle && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    fault_d = fault_q | (state_d == FAULT);
  end

  // State and counters; async reset forces RST_HOLD immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_HOLD;
      wait_q  <= '0;
      fault_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
    end
  end

  assign mem_fault    = fault_q;
  assign stall_cycles = stall_q;

endmodule
